// File: rtl/id_ex_elastic_reg.sv
// id_ex_elastic_reg
//   Elastic ID->EX pipeline register. It carries N_OPS operand words, a
//   control bundle and a metadata bundle (bit 0 predicted-MPC, bits 3:1
//   branch select) under valid/ready flow control.
//   SKID_EN=1 adds a second (skid) entry so up_ready_o comes straight from a
//   flop and one beat per cycle still flows. SKID_EN=0 keeps a single entry
//   and uses a combinational ready.
//   Flush squashes every held entry to a zero NOP bubble.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   flush       synchronous squash of all entries (drops the beat offered)
//   up_valid_i  upstream beat valid      up_ready_o  block can accept
//   up_ops_i    operand words (word k at [k*DATA_W +: DATA_W])
//   up_ctrl_i   control bundle           up_meta_i   metadata bundle
//   dn_valid_o  output beat valid        dn_ready_i  downstream accepts
//   dn_ops_o / dn_ctrl_o / dn_meta_o     held beat (all zero when invalid)
//   occ_o       number of entries held (0..2)
module id_ex_elastic_reg #(
  parameter int DATA_W  = 32,
  parameter int N_OPS   = 4,
  parameter int CTRL_W  = 26,
  parameter int META_W  = 4,
  parameter int SKID_EN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    up_valid_i,
  output logic                    up_ready_o,
  input  logic [N_OPS*DATA_W-1:0] up_ops_i,
  input  logic [CTRL_W-1:0]       up_ctrl_i,
  input  logic [META_W-1:0]       up_meta_i,
  output logic                    dn_valid_o,
  input  logic                    dn_ready_i,
  output logic [N_OPS*DATA_W-1:0] dn_ops_o,
  output logic [CTRL_W-1:0]       dn_ctrl_o,
  output logic [META_W-1:0]       dn_meta_o,
  output logic [1:0]              occ_o
);

  localparam int OPS_W    = N_OPS * DATA_W;
  localparam int BEAT_W   = OPS_W + CTRL_W + META_W;
  localparam bit USE_SKID = (SKID_EN != 0);

  // Main entry drives the outputs; skid entry only absorbs overflow.
  logic              main_vld_q, main_vld_d;
  logic [BEAT_W-1:0] main_q,     main_d;
  logic              skid_vld_q, skid_vld_d;
  logic [BEAT_W-1:0] skid_q,     skid_d;
  logic              rdy_q,      rdy_d;

  logic              up_xfer_s;
  logic              dn_xfer_s;
  logic [BEAT_W-1:0] beat_in_s;

  assign beat_in_s = {up_ops_i, up_ctrl_i, up_meta_i};

  // In skid mode ready is a pure flop; without the skid it must look at
  // dn_ready_i so a full single entry can be replaced in one cycle.
  assign up_ready_o = USE_SKID ? rdy_q : (~main_vld_q | dn_ready_i);
  assign up_xfer_s  = up_valid_i & up_ready_o;
  assign dn_xfer_s  = main_vld_q & dn_ready_i;

  assign dn_valid_o = main_vld_q;
  assign {dn_ops_o, dn_ctrl_o, dn_meta_o} = main_q;

  // The skid entry is only ever valid together with the main entry, so the
  // valid pair {main,skid} encodes occupancy 0, 1 or 2 directly.
  assign occ_o = {main_vld_q & skid_vld_q, main_vld_q ^ skid_vld_q};

  // Next-state for both entries: flush first, then the EMPTY/ONE/FULL rules.
  always_comb begin
    main_vld_d = main_vld_q;
    main_d     = main_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (flush) begin
      // The beat offered this cycle is dropped even if the handshake looks complete.
      main_vld_d = 1'b0;
      main_d     = {BEAT_W{1'b0}};
      skid_vld_d = 1'b0;
      skid_d     = {BEAT_W{1'b0}};
    end else begin
      case ({main_vld_q, skid_vld_q})
        2'b00: begin
          if (up_xfer_s) begin
            main_vld_d = 1'b1;
            main_d     = beat_in_s;
          end else begin
            main_vld_d = 1'b0;
            main_d     = {BEAT_W{1'b0}};
          end
        end
        2'b10: begin
          if (up_xfer_s && dn_xfer_s) begin
            main_d = beat_in_s;
          end else if (up_xfer_s && USE_SKID) begin
            skid_vld_d = 1'b1;
            skid_d     = beat_in_s;
          end else if (dn_xfer_s) begin
            main_vld_d = 1'b0;
            main_d     = {BEAT_W{1'b0}};
          end else begin
            main_d     = main_q;
          end
        end
        2'b11: begin
          if (dn_xfer_s) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
            skid_d     = {BEAT_W{1'b0}};
          end else begin
            main_d     = main_q;
          end
        end
        default: begin
          // Skid-without-main cannot be reached; recover to an empty bubble.
          main_vld_d = 1'b0;
          main_d     = {BEAT_W{1'b0}};
          skid_vld_d = 1'b0;
          skid_d     = {BEAT_W{1'b0}};
        end
      endcase
    end
    rdy_d = ~skid_vld_d;
  end

  // Entry storage and registered upstream ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_vld_q <= 1'b0;
      main_q     <= {BEAT_W{1'b0}};
      skid_vld_q <= 1'b0;
      skid_q     <= {BEAT_W{1'b0}};
      rdy_q      <= 1'b1;
    end else begin
      main_vld_q <= main_vld_d;
      main_q     <= main_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      rdy_q      <= rdy_d;
    end
  end

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
module tb_id_ex_elastic_reg;

  logic clk;
  logic rst_n;

  // dut_a: default build (SKID_EN=1, 4 x 32-bit operands)
  logic         a_flush, a_up_valid, a_up_ready, a_dn_valid, a_dn_ready;
  logic [127:0] a_up_ops, a_dn_ops;
  logic [25:0]  a_up_ctrl, a_dn_ctrl;
  logic [3:0]   a_up_meta, a_dn_meta;
  logic [1:0]   a_occ;

  // dut_b: single-entry build (SKID_EN=0)
  logic         b_flush, b_up_valid, b_up_ready, b_dn_valid, b_dn_ready;
  logic [127:0] b_up_ops, b_dn_ops;
  logic [25:0]  b_up_ctrl, b_dn_ctrl;
  logic [3:0]   b_up_meta, b_dn_meta;
  logic [1:0]   b_occ;

  // dut_w: wide build (N_OPS=2, DATA_W=64)
  logic         w_flush, w_up_valid, w_up_ready, w_dn_valid, w_dn_ready;
  logic [127:0] w_up_ops, w_dn_ops;
  logic [25:0]  w_up_ctrl, w_dn_ctrl;
  logic [3:0]   w_up_meta, w_dn_meta;
  logic [1:0]   w_occ;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [157:0] sb_q[$];
  logic [157:0] sb_exp;
  logic [157:0] prev_beat;
  logic         prev_hold;

  id_ex_elastic_reg dut_a (
    .clk(clk), .reset(rst_n), .flush(a_flush),
    .up_valid_i(a_up_valid), .up_ready_o(a_up_ready),
    .up_ops_i(a_up_ops), .up_ctrl_i(a_up_ctrl), .up_meta_i(a_up_meta),
    .dn_valid_o(a_dn_valid), .dn_ready_i(a_dn_ready),
    .dn_ops_o(a_dn_ops), .dn_ctrl_o(a_dn_ctrl), .dn_meta_o(a_dn_meta),
    .occ_o(a_occ)
  );

  id_ex_elastic_reg #(.SKID_EN(0)) dut_b (
    .clk(clk), .reset(rst_n), .flush(b_flush),
    .up_valid_i(b_up_valid), .up_ready_o(b_up_ready),
    .up_ops_i(b_up_ops), .up_ctrl_i(b_up_ctrl), .up_meta_i(b_up_meta),
    .dn_valid_o(b_dn_valid), .dn_ready_i(b_dn_ready),
    .dn_ops_o(b_dn_ops), .dn_ctrl_o(b_dn_ctrl), .dn_meta_o(b_dn_meta),
    .occ_o(b_occ)
  );

  id_ex_elastic_reg #(.N_OPS(2), .DATA_W(64)) dut_w (
    .clk(clk), .reset(rst_n), .flush(w_flush),
    .up_valid_i(w_up_valid), .up_ready_o(w_up_ready),
    .up_ops_i(w_up_ops), .up_ctrl_i(w_up_ctrl), .up_meta_i(w_up_meta),
    .dn_valid_o(w_dn_valid), .dn_ready_i(w_dn_ready),
    .dn_ops_o(w_dn_ops), .dn_ctrl_o(w_dn_ctrl), .dn_meta_o(w_dn_meta),
    .occ_o(w_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard for dut_a: push on accepted up beat, pop/compare on down beat.
  // Sampled on the falling edge, away from the capturing edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (a_dn_valid && a_dn_ready) begin
        chk_cnt++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_unexpected_beat got=%h required=none", {a_dn_ops, a_dn_ctrl, a_dn_meta});
        end else begin
          sb_exp = sb_q.pop_front();
          if ({a_dn_ops, a_dn_ctrl, a_dn_meta} !== sb_exp)
            $display("FAIL sb_order got=%h required=%h", {a_dn_ops, a_dn_ctrl, a_dn_meta}, sb_exp);
          else
            pass_cnt++;
        end
      end
      if (!a_dn_valid) begin
        chk_cnt++;
        if ({a_dn_ops, a_dn_ctrl, a_dn_meta} !== 158'd0)
          $display("FAIL bubble_zero got=%h required=0", {a_dn_ops, a_dn_ctrl, a_dn_meta});
        else
          pass_cnt++;
      end
      if (prev_hold) begin
        chk_cnt++;
        if ({a_dn_valid, a_dn_ops, a_dn_ctrl, a_dn_meta} !== {1'b1, prev_beat})
          $display("FAIL hold_stable got=%h required=%h", {a_dn_ops, a_dn_ctrl, a_dn_meta}, prev_beat);
        else
          pass_cnt++;
      end
      prev_hold = a_dn_valid && !a_dn_ready && !a_flush;
      prev_beat = {a_dn_ops, a_dn_ctrl, a_dn_meta};
      if (a_flush)
        sb_q.delete();
      else if (a_up_valid && a_up_ready)
        sb_q.push_back({a_up_ops, a_up_ctrl, a_up_meta});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_flush = 1'b0; a_up_valid = 1'b0; a_dn_ready = 1'b0;
    a_up_ops = 128'd0; a_up_ctrl = 26'd0; a_up_meta = 4'd0;
    b_flush = 1'b0; b_up_valid = 1'b0; b_dn_ready = 1'b0;
    b_up_ops = 128'd0; b_up_ctrl = 26'd0; b_up_meta = 4'd0;
    w_flush = 1'b0; w_up_valid = 1'b0; w_dn_ready = 1'b0;
    w_up_ops = 128'd0; w_up_ctrl = 26'd0; w_up_meta = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_cnt++;
    if ({a_dn_valid, a_dn_ops, a_dn_ctrl, a_dn_meta} !== 159'd0)
      $display("FAIL reset_a_outputs got=%h required=0", {a_dn_valid, a_dn_ops, a_dn_ctrl, a_dn_meta});
    else pass_cnt++;
    chk_cnt++;
    if ({a_up_ready, a_occ} !== 3'b100)
      $display("FAIL reset_a_ready_occ got=%b required=100", {a_up_ready, a_occ});
    else pass_cnt++;
    chk_cnt++;
    if ({b_dn_valid, b_up_ready, b_occ, w_dn_valid, w_up_ready, w_occ} !== 8'b0100_0100)
      $display("FAIL reset_b_w got=%b required=01000100", {b_dn_valid, b_up_ready, b_occ, w_dn_valid, w_up_ready, w_occ});
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    a_dn_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_up_valid = 1'b1;
      a_up_ops   = 128'd0;
      a_up_ops[31:0] = i;
      a_up_ctrl  = 26'd0;
      a_up_meta  = 4'(i);
      tick();
      chk_cnt++;
      if (a_dn_valid !== 1'b1 || a_dn_ops[31:0] !== 32'(i) || a_occ !== 2'd1 || a_up_ready !== 1'b1)
        $display("FAIL stream_word0 got=v%b w%0d occ%0d r%b required=v1 w%0d occ1 r1",
                 a_dn_valid, a_dn_ops[31:0], a_occ, a_up_ready, i);
      else pass_cnt++;
    end
    a_up_valid = 1'b0;
    tick();
    chk_cnt++;
    if (a_dn_valid !== 1'b0 || a_occ !== 2'd0)
      $display("FAIL stream_drain got=v%b occ%0d required=v0 occ0", a_dn_valid, a_occ);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    a_dn_ready = 1'b0;
    a_up_ops = 128'd0; a_up_meta = 4'd0;
    a_up_valid = 1'b1; a_up_ctrl = 26'h0000001;
    tick();
    chk_cnt++;
    if (a_occ !== 2'd1 || a_up_ready !== 1'b1)
      $display("FAIL bp_one got=occ%0d r%b required=occ1 r1", a_occ, a_up_ready);
    else pass_cnt++;
    a_up_ctrl = 26'h0000002;
    tick();
    chk_cnt++;
    if (a_occ !== 2'd2 || a_up_ready !== 1'b0 || a_dn_ctrl !== 26'h1)
      $display("FAIL bp_full got=occ%0d r%b c%h required=occ2 r0 c1", a_occ, a_up_ready, a_dn_ctrl);
    else pass_cnt++;
    a_up_ctrl = 26'h0000003;
    tick();
    chk_cnt++;
    if (a_occ !== 2'd2 || a_up_ready !== 1'b0 || a_dn_ctrl !== 26'h1)
      $display("FAIL bp_held_off got=occ%0d r%b c%h required=occ2 r0 c1", a_occ, a_up_ready, a_dn_ctrl);
    else pass_cnt++;
    a_dn_ready = 1'b1;
    tick();
    chk_cnt++;
    if (a_dn_ctrl !== 26'h2 || a_occ !== 2'd1 || a_up_ready !== 1'b1)
      $display("FAIL bp_second got=c%h occ%0d r%b required=c2 occ1 r1", a_dn_ctrl, a_occ, a_up_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (a_dn_ctrl !== 26'h3 || a_dn_valid !== 1'b1)
      $display("FAIL bp_third got=c%h v%b required=c3 v1", a_dn_ctrl, a_dn_valid);
    else pass_cnt++;
    a_up_valid = 1'b0;
    tick();
    chk_cnt++;
    if (a_dn_valid !== 1'b0 || sb_q.size() != 0)
      $display("FAIL bp_drained got=v%b pending%0d required=v0 pending0", a_dn_valid, sb_q.size());
    else pass_cnt++;
  endtask

  task automatic test_flush();
    // Flush while FULL
    a_dn_ready = 1'b0;
    a_up_valid = 1'b1; a_up_meta = 4'h1; a_up_ctrl = 26'h10;
    tick();
    a_up_ctrl = 26'h11;
    tick();
    chk_cnt++;
    if (a_occ !== 2'd2)
      $display("FAIL flush_prefill got=occ%0d required=occ2", a_occ);
    else pass_cnt++;
    a_flush = 1'b1; a_up_meta = 4'hF; a_up_ctrl = 26'h3F; a_dn_ready = 1'b1;
    tick();
    chk_cnt++;
    if (a_occ !== 2'd0 || a_dn_valid !== 1'b0 || a_dn_meta !== 4'h0 || a_up_ready !== 1'b1)
      $display("FAIL flush_full got=occ%0d v%b m%h r%b required=occ0 v0 m0 r1", a_occ, a_dn_valid, a_dn_meta, a_up_ready);
    else pass_cnt++;
    a_flush = 1'b0; a_up_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++;
      if (a_dn_valid !== 1'b0 || a_dn_meta !== 4'h0)
        $display("FAIL flush_no_replay got=v%b m%h required=v0 m0", a_dn_valid, a_dn_meta);
      else pass_cnt++;
    end
    // Flush with one entry: handshake looks complete but the beat is dropped
    a_dn_ready = 1'b0; a_up_valid = 1'b1; a_up_meta = 4'h2; a_up_ctrl = 26'h20;
    tick();
    a_flush = 1'b1; a_up_meta = 4'hF;
    chk_cnt++;
    if (a_up_ready !== 1'b1)
      $display("FAIL flush_one_ready got=%b required=1", a_up_ready);
    else pass_cnt++;
    tick();
    a_flush = 1'b0; a_up_valid = 1'b0; a_dn_ready = 1'b1;
    chk_cnt++;
    if (a_occ !== 2'd0 || a_dn_valid !== 1'b0 || a_up_ready !== 1'b1)
      $display("FAIL flush_one got=occ%0d v%b r%b required=occ0 v0 r1", a_occ, a_dn_valid, a_up_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (a_dn_valid !== 1'b0)
      $display("FAIL flush_one_dropped got=v%b required=v0", a_dn_valid);
    else pass_cnt++;
  endtask

  task automatic test_skid0_stall();
    b_dn_ready = 1'b0; b_up_valid = 1'b1; b_up_ctrl = 26'h5; b_up_ops = 128'd0;
    tick();
    chk_cnt++;
    if (b_dn_valid !== 1'b1 || b_up_ready !== 1'b0 || b_occ !== 2'd1)
      $display("FAIL s0_stall got=v%b r%b occ%0d required=v1 r0 occ1", b_dn_valid, b_up_ready, b_occ);
    else pass_cnt++;
    b_up_ctrl = 26'h7;
    tick();
    chk_cnt++;
    if (b_dn_ctrl !== 26'h5 || b_occ !== 2'd1)
      $display("FAIL s0_hold got=c%h occ%0d required=c5 occ1", b_dn_ctrl, b_occ);
    else pass_cnt++;
    b_dn_ready = 1'b1; b_up_ctrl = 26'h6;
    #1;
    chk_cnt++;
    if (b_up_ready !== 1'b1)
      $display("FAIL s0_comb_ready got=%b required=1", b_up_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (b_dn_ctrl !== 26'h6 || b_dn_valid !== 1'b1)
      $display("FAIL s0_replace got=c%h v%b required=c6 v1", b_dn_ctrl, b_dn_valid);
    else pass_cnt++;
    b_up_ctrl = 26'h0;
    for (int i = 1; i <= 4; i++) begin
      b_up_ops = 128'd0;
      b_up_ops[31:0] = 32'(i * 3);
      tick();
      chk_cnt++;
      if (b_dn_valid !== 1'b1 || b_dn_ops[31:0] !== 32'(i * 3))
        $display("FAIL s0_stream got=v%b w%0d required=v1 w%0d", b_dn_valid, b_dn_ops[31:0], i * 3);
      else pass_cnt++;
    end
    b_up_valid = 1'b0;
    tick();
    chk_cnt++;
    if (b_dn_valid !== 1'b0 || b_dn_ops !== 128'd0 || b_occ !== 2'd0)
      $display("FAIL s0_drain got=v%b occ%0d required=v0 occ0", b_dn_valid, b_occ);
    else pass_cnt++;
  endtask

  task automatic test_width();
    w_dn_ready = 1'b1; w_up_valid = 1'b1;
    w_up_ops = {64'hDEAD_0123_4567_89AB, 64'hBEEF_FEDC_BA98_7654};
    tick();
    w_up_valid = 1'b0;
    chk_cnt++;
    if (w_dn_valid !== 1'b1 || w_dn_ops[63:0] !== 64'hBEEF_FEDC_BA98_7654 ||
        w_dn_ops[127:64] !== 64'hDEAD_0123_4567_89AB)
      $display("FAIL width_words got=v%b %h required=v1 dead0123456789abbeeffedcba987654", w_dn_valid, w_dn_ops);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (w_dn_valid !== 1'b0 || w_dn_ops !== 128'd0)
      $display("FAIL width_drain got=v%b %h required=v0 0", w_dn_valid, w_dn_ops);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    a_dn_ready = 1'b0; a_up_valid = 1'b1; a_up_ctrl = 26'h31; a_up_meta = 4'h5;
    a_up_ops = 128'hA5A5;
    tick();
    a_up_ctrl = 26'h32;
    tick();
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (a_dn_valid !== 1'b0 || a_occ !== 2'd0 || a_up_ready !== 1'b1 ||
        {a_dn_ops, a_dn_ctrl, a_dn_meta} !== 158'd0)
      $display("FAIL reset_mid got=v%b occ%0d r%b required=v0 occ0 r1", a_dn_valid, a_occ, a_up_ready);
    else pass_cnt++;
    a_up_valid = 1'b0; a_dn_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk_cnt++;
    if (a_dn_valid !== 1'b0 || a_occ !== 2'd0)
      $display("FAIL reset_mid_discard got=v%b occ%0d required=v0 occ0", a_dn_valid, a_occ);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0_stall();
    test_width();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
